// File: rtl/spi_pkg.sv
// Shared definitions for the SPI initiator: op codes, frame geometry, FSM states.
package spi_pkg;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_SHIFT,
    ST_GAP,
    ST_READ
  } state_t;

endpackage

// File: rtl/spi_master.sv
// SPI initiator: serialises {op, data} MSB first under ss_n and, for the
// read-data op, waits RD_GAP idle cycles then captures one byte from MISO.
// Every output is a flop; the next-state logic computes next output values.
module spi_master
  import spi_pkg::*;
#(
  parameter int RD_GAP    = 2,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [ADDR_SIZE-1:0] cmd_data,
  output logic                 rsp_valid,
  output logic [7:0]           rsp_data,
  output logic                 busy,
  output logic                 ss_n,
  output logic                 MOSI,
  input  logic                 MISO
);

  localparam logic [3:0] LP_SHIFT_LAST = 4'(FRAME_BITS - 1);
  localparam logic [3:0] LP_GAP_LAST   = 4'(RD_GAP - 1);
  localparam logic [3:0] LP_READ_LAST  = 4'(DATA_BITS - 1);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [9:0]  r_sh, w_sh_nxt;
  logic [1:0]  r_op, w_op_nxt;
  logic [7:0]  r_rx, w_rx_nxt;
  logic [7:0]  r_rsp_data, w_rsp_data_nxt;
  logic        r_rsp_valid, w_rsp_valid_nxt;
  logic        r_ss_n, w_ss_n_nxt;
  logic        r_mosi, w_mosi_nxt;
  logic        r_ready, r_busy;
  logic        w_ready_nxt;

  // State and registered outputs; reset drops ss_n high immediately and abandons the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_sh        <= '0;
      r_op        <= '0;
      r_rx        <= '0;
      r_rsp_data  <= '0;
      r_rsp_valid <= 1'b0;
      r_ss_n      <= 1'b1;
      r_mosi      <= 1'b0;
      r_ready     <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_sh        <= w_sh_nxt;
      r_op        <= w_op_nxt;
      r_rx        <= w_rx_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_ss_n      <= w_ss_n_nxt;
      r_mosi      <= w_mosi_nxt;
      r_ready     <= w_ready_nxt;
      r_busy      <= ~w_ready_nxt;
    end
  end

  // Next state plus the values the output flops will show during that state.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_sh_nxt        = r_sh;
    w_op_nxt        = r_op;
    w_rx_nxt        = r_rx;
    w_rsp_data_nxt  = r_rsp_data;
    w_rsp_valid_nxt = 1'b0;
    w_ss_n_nxt      = 1'b0;
    w_mosi_nxt      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_ss_n_nxt = 1'b1;
        if (cmd_valid) begin
          w_state_nxt = ST_START;
          w_sh_nxt    = {cmd_op, cmd_data};
          w_op_nxt    = cmd_op;
          w_ss_n_nxt  = 1'b0;
          w_mosi_nxt  = cmd_op[1];   // command-check bit ahead of the word
        end
      end
      ST_START: begin
        w_state_nxt = ST_SHIFT;
        w_mosi_nxt  = r_sh[9];
        w_sh_nxt    = {r_sh[8:0], 1'b0};
        w_cnt_nxt   = '0;
      end
      ST_SHIFT: begin
        if (r_cnt == LP_SHIFT_LAST) begin
          w_cnt_nxt = '0;
          if (r_op == OP_RD_DATA) begin
            w_state_nxt = ST_GAP;
          end else begin
            w_state_nxt = ST_IDLE;
            w_ss_n_nxt  = 1'b1;
          end
        end else begin
          w_mosi_nxt = r_sh[9];
          w_sh_nxt   = {r_sh[8:0], 1'b0};
          w_cnt_nxt  = r_cnt + 4'd1;
        end
      end
      ST_GAP: begin
        if (r_cnt == LP_GAP_LAST) begin
          w_state_nxt = ST_READ;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      ST_READ: begin
        w_rx_nxt = {r_rx[6:0], MISO};
        if (r_cnt == LP_READ_LAST) begin
          w_state_nxt     = ST_IDLE;
          w_ss_n_nxt      = 1'b1;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_data_nxt  = {r_rx[6:0], MISO};
          w_cnt_nxt       = '0;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_ss_n_nxt  = 1'b1;
      end
    endcase
    w_ready_nxt = (w_state_nxt == ST_IDLE);
  end

  assign cmd_ready = r_ready;
  assign busy      = r_busy;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign ss_n      = r_ss_n;
  assign MOSI      = r_mosi;

endmodule
